fetch_unit: RTL and testbench

Fetch-stage controller for the pipelined MIPS core. It sits directly upstream of the instruction memory and owns the program counter. It drives the memory's byte read address, boots the PC from the memory-supplied start address, and handles stall, flush and branch/jump redirects. It captures the returned instruction into the IF/ID pipeline register consumed by decode.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_unit_if_id_reg.sv | 33 +++
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC     = 32'h0040_0000;
    localparam logic [31:0] SYSCALL_WORD = 32'h0000_000C;
    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

    // IF/ID pipeline register contents, 65 bits.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    // Instructions are word aligned; any low address bit set is a bad target.
    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: clear (bubble) beats hold (stall) beats load.
// A bubble zeroes the instruction and valid bit but keeps pc_plus4.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic   clock,
    input  logic   reset_n,
    input  logic   hold_i,
    input  logic   clear_i,
    input  logic   load_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t reg_q;

    // Register update with bubble/hold/load priority.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reg_q <= '0;
        end else if (clear_i) begin
            reg_q.instr <= NOP_WORD;
            reg_q.valid <= 1'b0;
        end else if (hold_i) begin
            reg_q <= reg_q;
        end else if (load_i) begin
            reg_q <= d_i;
        end
    end

    assign q_o = reg_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch-stage controller: owns the PC, boots from start_addr, handles
// stall / flush / redirect, halts on SYSCALL and traps misaligned redirects.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// BOOT     | one cycle at RESET_PC; loads PC from start_addr
// RUN      | normal fetch, one word per unstalled edge
// HALT     | SYSCALL seen; PC frozen until an aligned redirect
// FAULT    | misaligned redirect seen; frozen until reset
module fetch_unit
    import fetch_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] start_addr,
    input  logic [31:0] mem_instruction,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] read_address,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        halted,
    output logic        fetch_fault
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic         halted_q;
    logic         fault_q;

    logic [31:0]  pc_plus4;
    logic         redirect_bad;
    logic         is_syscall;
    logic         ifid_hold;
    logic         ifid_clear;
    logic         ifid_load;
    if_id_t       ifid_d;
    if_id_t       ifid_q;

    // IF/ID control decode; a redirect always bubbles, even over a stall.
    always_comb begin
        pc_plus4     = pc_q + 32'd4;
        redirect_bad = redirect_valid && misaligned(redirect_target);
        is_syscall   = (mem_instruction == SYSCALL_WORD);
        ifid_d       = '{instr: mem_instruction, pc_plus4: pc_plus4, valid: 1'b1};
        ifid_hold    = 1'b0;
        ifid_clear   = 1'b0;
        ifid_load    = 1'b0;
        case (state_q)
            ST_BOOT: begin
                ifid_hold = 1'b1;
            end
            ST_RUN: begin
                ifid_clear = redirect_valid || flush;
                ifid_hold  = stall;
                ifid_load  = 1'b1;
            end
            ST_HALT: begin
                // SYSCALL is presented once, then bubbles unless stalled.
                ifid_clear = redirect_valid || flush || !stall;
                ifid_hold  = stall;
            end
            default: begin
                ifid_clear = 1'b1;
            end
        endcase
    end

    // FSM, PC register and registered status flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    pc_q    <= start_addr;
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (redirect_bad) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                    end else if (redirect_valid) begin
                        pc_q <= redirect_target;
                    end else if (stall) begin
                        pc_q <= pc_q;
                    end else if (flush) begin
                        pc_q <= pc_plus4;
                    end else if (is_syscall) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        pc_q <= pc_plus4;
                    end
                end
                ST_HALT: begin
                    if (redirect_bad) begin
                        state_q  <= ST_FAULT;
                        halted_q <= 1'b0;
                        fault_q  <= 1'b1;
                    end else if (redirect_valid) begin
                        pc_q     <= redirect_target;
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_FAULT;
                end
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clock   (clock),
        .reset_n (reset_n),
        .hold_i  (ifid_hold),
        .clear_i (ifid_clear),
        .load_i  (ifid_load),
        .d_i     (ifid_d),
        .q_o     (ifid_q)
    );

    assign read_address   = pc_q;
    assign if_id_instr    = ifid_q.instr;
    assign if_id_pc_plus4 = ifid_q.pc_plus4;
    assign if_id_valid    = ifid_q.valid;
    assign halted         = halted_q;
    assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected IF/ID captures,
// a negedge monitor pops and compares whenever a new valid word appears.
module tb_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic [31:0] start_addr;
    logic [31:0] mem_instruction;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] read_address;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        halted;
    logic        fetch_fault;

    int n_pass  = 0;
    int n_total = 0;

    logic [63:0] exp_q[$];
    logic [63:0] last_e = '0;
    logic        stall_prev = 1'b0;
    logic [31:0] mem [0:255];

    fetch_unit dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start_addr      (start_addr),
        .mem_instruction (mem_instruction),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .read_address    (read_address),
        .if_id_instr     (if_id_instr),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .if_id_valid     (if_id_valid),
        .halted          (halted),
        .fetch_fault     (fetch_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory: 256 words at 0x0040_0000, zero elsewhere.
    always_comb begin
        if (read_address[31:10] == 22'h001000)
            mem_instruction = mem[read_address[9:2]];
        else
            mem_instruction = 32'h0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(posedge clock) stall_prev <= stall;

    // Monitor: a new valid word pops the scoreboard; a stalled one must hold.
    always @(negedge clock) begin
        if (reset_n && if_id_valid) begin
            if (!stall_prev) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL mon_unexpected: got instr %h pc4 %h expected no valid word",
                             if_id_instr, if_id_pc_plus4);
                end else begin
                    last_e = exp_q.pop_front();
                    check("mon_instr", if_id_instr, last_e[63:32]);
                    check("mon_pc4", if_id_pc_plus4, last_e[31:0]);
                end
            end else begin
                check("hold_instr", if_id_instr, last_e[63:32]);
                check("hold_pc4", if_id_pc_plus4, last_e[31:0]);
            end
        end
    end

    // One cycle: drive inputs, optionally expect a capture, check PC after the edge.
    task automatic cyc(input string name, input logic st, input logic fl, input logic rv,
                       input logic [31:0] rt, input logic push, input logic [31:0] e_instr,
                       input logic [31:0] e_pc4, input logic [31:0] e_ra);
        stall           = st;
        flush           = fl;
        redirect_valid  = rv;
        redirect_target = rt;
        if (push) exp_q.push_back({e_instr, e_pc4});
        @(posedge clock);
        #1;
        check({name, "_ra"}, read_address, e_ra);
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_ra"}, read_address, 32'h0040_0000);
        check({name, "_instr"}, if_id_instr, 32'h0);
        check({name, "_pc4"}, if_id_pc_plus4, 32'h0);
        check({name, "_valid"}, {31'h0, if_id_valid}, 32'h0);
        check({name, "_halted"}, {31'h0, halted}, 32'h0);
        check({name, "_fault"}, {31'h0, fetch_fault}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i * 4);
        mem[0]  = 32'h0;
        mem[2]  = 32'h0000_000C;
        mem[8]  = 32'h0000_1111;
        mem[9]  = 32'h0000_2222;
        reset_n         = 1'b0;
        start_addr      = 32'h0040_0020;
        stall           = 1'b0;
        flush           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;

        @(posedge clock);
        #1;
        check_reset_values("reset");
        reset_n = 1'b1;

        // boot and first fetches
        cyc("boot",  0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0040_0020);
        cyc("f20",   0, 0, 0, 32'h0, 1, 32'h0000_1111, 32'h0040_0024, 32'h0040_0024);
        cyc("f24",   0, 0, 0, 32'h0, 1, 32'h0000_2222, 32'h0040_0028, 32'h0040_0028);

        // stall held three cycles
        for (int i = 0; i < 3; i++)
            cyc("stall", 1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0040_0028);
        check("stall_instr", if_id_instr, 32'h0000_2222);
        cyc("f28",   0, 0, 0, 32'h0, 1, 32'h1000_0028, 32'h0040_002C, 32'h0040_002C);

        // redirect together with stall
        cyc("redir_st", 1, 0, 1, 32'h0040_0100, 0, 32'h0, 32'h0, 32'h0040_0100);
        check("redir_valid", {31'h0, if_id_valid}, 32'h0);
        cyc("f100",  0, 0, 0, 32'h0, 1, 32'h1000_0100, 32'h0040_0104, 32'h0040_0104);

        // flush alone
        cyc("flush", 0, 1, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0040_0108);
        check("flush_valid", {31'h0, if_id_valid}, 32'h0);
        check("flush_pc4", if_id_pc_plus4, 32'h0040_0104);
        cyc("f108",  0, 0, 0, 32'h0, 1, 32'h1000_0108, 32'h0040_010C, 32'h0040_010C);

        // SYSCALL at 0x0040_0008
        cyc("redir04", 0, 0, 1, 32'h0040_0004, 0, 32'h0, 32'h0, 32'h0040_0004);
        cyc("f04",   0, 0, 0, 32'h0, 1, 32'h1000_0004, 32'h0040_0008, 32'h0040_0008);
        cyc("sys",   0, 0, 0, 32'h0, 1, 32'h0000_000C, 32'h0040_000C, 32'h0040_0008);
        check("sys_halted", {31'h0, halted}, 32'h1);
        check("sys_valid", {31'h0, if_id_valid}, 32'h1);
        cyc("halt",  0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0040_0008);
        check("halt_valid", {31'h0, if_id_valid}, 32'h0);
        check("halt_halted", {31'h0, halted}, 32'h1);
        cyc("unhalt", 0, 0, 1, 32'h0040_0040, 0, 32'h0, 32'h0, 32'h0040_0040);
        check("unhalt_halted", {31'h0, halted}, 32'h0);
        cyc("f40",   0, 0, 0, 32'h0, 1, 32'h1000_0040, 32'h0040_0044, 32'h0040_0044);

        // PC wrap through flush
        cyc("redirtop", 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 32'hFFFF_FFFC);
        cyc("wrap",  0, 1, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0000_0000);
        cyc("f0",    0, 0, 0, 32'h0, 1, 32'h0000_0000, 32'h0000_0004, 32'h0000_0004);

        // misaligned redirect, then redirects ignored
        cyc("misal", 0, 0, 1, 32'h0040_0102, 0, 32'h0, 32'h0, 32'h0000_0004);
        check("misal_fault", {31'h0, fetch_fault}, 32'h1);
        check("misal_valid", {31'h0, if_id_valid}, 32'h0);
        cyc("fault_redir", 0, 0, 1, 32'h0040_0100, 0, 32'h0, 32'h0, 32'h0000_0004);
        check("fault_sticky", {31'h0, fetch_fault}, 32'h1);
        cyc("fault_idle", 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0000_0004);

        // asynchronous reset mid-cycle
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cyc("reboot", 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0040_0020);
        cyc("rf20",  0, 0, 0, 32'h0, 1, 32'h0000_1111, 32'h0040_0024, 32'h0040_0024);

        @(negedge clock);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
